fp_divider_seq: RTL and testbench

//  Iterative IEEE-754 single-precision divider (a / b), inverse datapath of the FP multiplier.
//  - Exponents are subtracted, not added; mantissas use restoring division.
//  - Sits beside the multiplier in the FP unit; one operation in flight; fixed latency.

---
 rtl/fp_div_pkg.sv | 34 +++
 rtl/mant_restoring_div.sv | 64 ++++++
 rtl/fp_divider_seq.sv | 187 ++++++++++++++++++
 tb/tb_fp_divider_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential single-precision divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_div_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int SIG_W  = MAN_W + 1;      // significand with hidden one
    localparam int QB     = MAN_W + 3;      // quotient bits: 24 + guard + sticky slot
    localparam int CNT_W  = $clog2(QB);
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    // Bit positions inside the 4-bit flags bus.
    localparam int FLAG_INV = 3;
    localparam int FLAG_DBZ = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/mant_restoring_div.sv
// Restoring divider: floor(dividend * 2^(QB-1) / divisor) plus remainder, one quotient bit per cycle.
// Latency: QB cycles after i_start; o_last is high during the cycle that produces the final bit.
// Backpressure: none; i_start while busy restarts the division.
// Ports: clk, rst_n (async active-low), i_start, i_dividend, i_divisor,
//        o_busy, o_last, o_quot (QB bits, MSB first), o_rem (final remainder).
module mant_restoring_div
    import fp_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [SIG_W-1:0] i_dividend,
    input  logic [SIG_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_last,
    output logic [QB-1:0]    o_quot,
    output logic [SIG_W-1:0] o_rem
);

    // Partial remainder is always < 2*divisor, so one extra bit suffices.
    logic [SIG_W:0]   r_rem;
    logic [SIG_W-1:0] r_div;
    logic [QB-1:0]    r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic             w_ge;
    logic [SIG_W:0]   w_sub;

    assign w_ge   = (r_rem >= {1'b0, r_div});
    assign w_sub  = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
    assign o_last = r_busy && (r_cnt == CNT_W'(QB - 1));
    assign o_busy = r_busy;
    assign o_quot = r_quot;
    assign o_rem  = r_rem[SIG_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= {1'b0, i_dividend};
            r_div  <= i_divisor;
            r_quot <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_quot <= {r_quot[QB-2:0], w_ge};
            r_cnt  <= r_cnt + 1'b1;
            if (o_last) begin
                // Keep the final remainder unshifted; only its non-zeroness matters.
                r_rem  <= w_sub;
                r_busy <= 1'b0;
            end else begin
                // w_sub < divisor, so its top bit is always zero.
                r_rem  <= {w_sub[SIG_W-1:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/fp_divider_seq.sv
// Iterative IEEE-754 single-precision divider q = a / b with flush-to-zero inputs and no subnormal outputs.
// Latency: fixed 28 cycles per op (accept edge, 26 quotient edges, 1 normalise edge); one op in flight.
// Backpressure: in_ready low while busy, in_valid ignored then; no output backpressure (out_valid is a pulse).
// Ports: clk, rst_n (async active-low), in_valid/in_ready, a, b -> out_valid, q, flags {inv, dbz, ovf, unf}.
// Build option: FPDIV_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise results are truncated.
module fp_divider_seq
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] q,
    output logic [3:0]  flags
);

    state_t              r_state;
    logic                r_in_rdy;
    logic                r_out_vld;
    logic [31:0]         r_q;
    logic [3:0]          r_flags;
    logic                r_sign;
    logic signed [9:0]   r_exp;
    logic                r_special;
    logic [31:0]         r_spec_q;
    logic [3:0]          r_spec_flags;

    fp32_t               w_a, w_b;
    logic                w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    logic                w_sign, w_accept;
    logic signed [9:0]   w_exp_diff;
    logic                w_spec;
    logic [31:0]         w_spec_q;
    logic [3:0]          w_spec_flags;

    logic                w_div_last, w_unused_div_busy;
    logic [QB-1:0]       w_quot;
    logic [SIG_W-1:0]    w_rem;

    assign w_a = fp32_t'(a);
    assign w_b = fp32_t'(b);

    // Exponent 0 covers both true zero and subnormals, which are flushed.
    assign w_a_zero = (w_a.exp == '0);
    assign w_b_zero = (w_b.exp == '0);
    assign w_a_inf  = (w_a.exp == '1) && (w_a.frac == '0);
    assign w_b_inf  = (w_b.exp == '1) && (w_b.frac == '0);
    assign w_a_nan  = (w_a.exp == '1) && (w_a.frac != '0);
    assign w_b_nan  = (w_b.exp == '1) && (w_b.frac != '0);
    assign w_sign   = w_a.sign ^ w_b.sign;
    assign w_accept = in_valid && r_in_rdy;

    assign w_exp_diff = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp}) + $signed(10'(BIAS));

    // Special-case priority: invalid first, then inf dividend (so inf/0 is plain inf), then /0.
    always_comb begin
        w_spec       = 1'b0;
        w_spec_q     = '0;
        w_spec_flags = '0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec                 = 1'b1;
            w_spec_q               = QNAN;
            w_spec_flags[FLAG_INV] = 1'b1;
        end else if (w_a_inf) begin
            w_spec   = 1'b1;
            w_spec_q = {w_sign, POS_INF[30:0]};
        end else if (w_b_zero) begin
            w_spec                 = 1'b1;
            w_spec_q               = {w_sign, POS_INF[30:0]};
            w_spec_flags[FLAG_DBZ] = 1'b1;
        end else if (w_a_zero || w_b_inf) begin
            w_spec   = 1'b1;
            w_spec_q = {w_sign, 31'd0};
        end
    end

    // The divider runs even for specials so latency never depends on the operands.
    mant_restoring_div u_mant_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_accept),
        .i_dividend ({1'b1, w_a.frac}),
        .i_divisor  ({1'b1, w_b.frac}),
        .o_busy     (w_unused_div_busy),
        .o_last     (w_div_last),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Normalise: the quotient lies in (2^24, 2^26), so at most one bit of shift.
    logic                w_q_hi;
    logic [SIG_W-1:0]    w_mant;
    logic                w_g, w_s, w_inc, w_carry;
    logic [SIG_W:0]      w_mant_r;
    logic [MAN_W-1:0]    w_frac;
    logic signed [9:0]   w_exp_n, w_exp_r;
    logic [31:0]         w_res_q;
    logic [3:0]          w_res_flags;

    assign w_q_hi  = w_quot[QB-1];
    assign w_mant  = w_q_hi ? w_quot[QB-1:2] : w_quot[QB-2:1];
    assign w_g     = w_q_hi ? w_quot[1] : w_quot[0];
    assign w_s     = (w_q_hi && w_quot[0]) || (w_rem != '0);
    assign w_exp_n = r_exp - (w_q_hi ? 10'sd0 : 10'sd1);

`ifdef FPDIV_ROUND_NEAREST_EN
    assign w_inc = w_g && (w_s || w_mant[0]);
`else
    logic w_unused_gs;
    assign w_unused_gs = w_g ^ w_s;
    assign w_inc       = 1'b0;
`endif

    assign w_mant_r = {1'b0, w_mant} + (SIG_W + 1)'(w_inc);
    assign w_carry  = w_mant_r[SIG_W];
    // On carry-out the significand becomes exactly 1.0, so the fraction is zero.
    assign w_frac   = w_carry ? '0 : w_mant_r[MAN_W-1:0];
    assign w_exp_r  = w_exp_n + (w_carry ? 10'sd1 : 10'sd0);

    always_comb begin
        w_res_q     = {r_sign, w_exp_r[EXP_W-1:0], w_frac};
        w_res_flags = '0;
        if (r_special) begin
            w_res_q     = r_spec_q;
            w_res_flags = r_spec_flags;
        end else if (w_exp_r >= 10'sd255) begin
            w_res_q               = {r_sign, POS_INF[30:0]};
            w_res_flags[FLAG_OVF] = 1'b1;
        end else if (w_exp_r <= 10'sd0) begin
            w_res_q               = {r_sign, 31'd0};
            w_res_flags[FLAG_UNF] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_in_rdy     <= 1'b1;
            r_out_vld    <= 1'b0;
            r_q          <= '0;
            r_flags      <= '0;
            r_sign       <= 1'b0;
            r_exp        <= '0;
            r_special    <= 1'b0;
            r_spec_q     <= '0;
            r_spec_flags <= '0;
        end else begin
            r_out_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign       <= w_sign;
                        r_exp        <= w_exp_diff;
                        r_special    <= w_spec;
                        r_spec_q     <= w_spec_q;
                        r_spec_flags <= w_spec_flags;
                        r_in_rdy     <= 1'b0;
                        r_state      <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_div_last) r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_q       <= w_res_q;
                    r_flags   <= w_res_flags;
                    r_out_vld <= 1'b1;
                    r_in_rdy  <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_in_rdy <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = r_out_vld;
    assign q         = r_q;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Self-checking bench for fp_divider_seq: directed corner cases, reset abort, back-to-back accepts, random ops.
// Latency: expects out_valid 27 edges after the accept edge and a one-cycle pulse.
// Backpressure: in_valid is held high during busy periods to show it is ignored.
module tb_fp_divider_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] q;
    logic [3:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    fp_divider_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .q         (q),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer quotient of the significands, then the rounding/range rules.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] rq, output logic [3:0] rf);
        int     ex, ey, e;
        longint fx, fy, num, den, qq, rr, m;
        bit     sg, nx, ny, ix, iy, zx, zy, g, s;
        ex = int'(x[30:23]);  ey = int'(y[30:23]);
        fx = longint'(x[22:0]); fy = longint'(y[22:0]);
        sg = x[31] ^ y[31];
        nx = (ex == 255) && (fx != 0);  ny = (ey == 255) && (fy != 0);
        ix = (ex == 255) && (fx == 0);  iy = (ey == 255) && (fy == 0);
        zx = (ex == 0);                 zy = (ey == 0);
        rf = 4'b0000;
        if (nx || ny || (zx && zy) || (ix && iy)) begin rq = 32'h7FC00000; rf = 4'b1000; return; end
        if (ix) begin rq = {sg, 8'hFF, 23'd0}; return; end
        if (zy) begin rq = {sg, 8'hFF, 23'd0}; rf = 4'b0100; return; end
        if (zx || iy) begin rq = {sg, 31'd0}; return; end
        num = (fx + 64'd8388608) * 64'd33554432;
        den = fy + 64'd8388608;
        qq  = num / den;
        rr  = num % den;
        e   = ex - ey + 127;
        if (qq >= 64'd33554432) begin
            m = qq / 4; g = ((qq / 2) % 2) != 0; s = ((qq % 2) != 0) || (rr != 0);
        end else begin
            m = qq / 2; g = (qq % 2) != 0; s = (rr != 0); e = e - 1;
        end
`ifdef FPDIV_ROUND_NEAREST_EN
        if (g && (s || (m % 2 != 0))) m = m + 1;
`endif
        if (m == 64'd16777216) begin m = 64'd8388608; e = e + 1; end
        if (e >= 255)    begin rq = {sg, 8'hFF, 23'd0}; rf = 4'b0010; end
        else if (e <= 0) begin rq = {sg, 31'd0};        rf = 4'b0001; end
        else             rq = {sg, 8'(e), 23'(m % 64'd8388608)};
    endfunction

    // One operation: accept, bounded wait for the result, confirm the pulse is one cycle wide.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] gq, output logic [3:0] gf, output int lat);
        @(negedge clk);
        check_val("idle.in_ready", 32'(in_ready), 32'd1);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        check_val("busy.in_ready", 32'(in_ready), 32'd0);
        lat = 0;
        gq = 32'hDEADBEEF; gf = 4'hF;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; gq = q; gf = flags; break; end
        end
        check_val("latency", 32'(lat), 32'd27);
        @(posedge clk); #1;
        check_val("pulse_width", 32'(out_valid), 32'd0);
    endtask

    logic [31:0] fa_t [7];
    logic [31:0] fb_t [7];
    logic [31:0] fq_t [7];
    logic [3:0]  ff_t [7];

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: v[30:0] = 31'd0;
            1: v[30:0] = {8'hFF, 23'd0};
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'h00;
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] gq, eq, x, y;
        logic [3:0]  gf, ef;
        int          lat, n_acc, n_out, seen;
        int          acc_cyc [$];
        logic [31:0] exp_q [$];
        logic [3:0]  exp_f [$];

        fa_t = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F000000, 32'h00800000, 32'h7F800000};
        fb_t = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000, 32'h4F000000, 32'hC0000000};
`ifdef FPDIV_ROUND_NEAREST_EN
        fq_t = '{32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'hFF800000};
`else
        fq_t = '{32'h40400000, 32'h3EAAAAAA, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'hFF800000};
`endif
        ff_t = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b0000};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        #12;
        check_val("rst.in_ready", 32'(in_ready), 32'd1);
        check_val("rst.out_valid", 32'(out_valid), 32'd0);
        check_val("rst.q", q, 32'd0);
        check_val("rst.flags", 32'(flags), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed cases with hand-derived results.
        for (int i = 0; i < 7; i++) begin
            do_op(fa_t[i], fb_t[i], gq, gf, lat);
            check_val("dir.q", gq, fq_t[i]);
            check_val("dir.flags", 32'(gf), 32'(ff_t[i]));
        end

        // Reset ten cycles into an operation aborts it.
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0; #1;
        check_val("abort.out_valid", 32'(out_valid), 32'd0);
        check_val("abort.in_ready", 32'(in_ready), 32'd1);
        check_val("abort.q", q, 32'd0);
        check_val("abort.flags", 32'(flags), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_val("abort.no_result", 32'(seen), 32'd0);
        do_op(32'h40C00000, 32'h40000000, gq, gf, lat);
        check_val("post_abort.q", gq, 32'h40400000);

        // in_valid held high: accepts exactly 28 cycles apart, garbage during DIV ignored.
        n_acc = 0; n_out = 0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                if (n_acc < 3) begin
                    x = rand_fp(); y = rand_fp();
                    ref_div(x, y, eq, ef);
                    exp_q.push_back(eq); exp_f.push_back(ef);
                    acc_cyc.push_back(cyc);
                    a = x; b = y; in_valid = 1'b1;
                    n_acc++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                n_out++;
                if (exp_q.size() > 0) begin
                    check_val("b2b.q", q, exp_q.pop_front());
                    check_val("b2b.flags", 32'(flags), 32'(exp_f.pop_front()));
                end
            end
        end
        in_valid = 1'b0;
        check_val("b2b.results", 32'(n_out), 32'd3);
        check_val("b2b.accepts", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            check_val("b2b.gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd28);
            check_val("b2b.gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd28);
        end

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            x = rand_fp(); y = rand_fp();
            ref_div(x, y, eq, ef);
            do_op(x, y, gq, gf, lat);
            check_val("rnd.q", gq, eq);
            check_val("rnd.flags", 32'(gf), 32'(ef));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
